// File: rtl/byte_pair_packer_pkg.sv
// Shared types and helpers for the byte-pair packer and its output FIFO.
package byte_pair_packer_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [15:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    HALF = 1'b1
  } pair_state_e;

  localparam byte_t PAD_DEFAULT = 8'h00;

  // Constant-foldable ceiling log2, used for FIFO pointer widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_pair_packer_if.sv
// Byte input, word output and status signals of the byte-pair packer.
interface byte_pair_packer_if;
  import byte_pair_packer_pkg::*;

  byte_t       __in0;   // byte from the slicing stage
  logic        __in1;   // byte valid
  logic        __in2;   // flush request (level)
  logic        __in3;   // downstream ready
  word_t       __out0;  // packed word at FIFO head
  logic        __out1;  // word valid
  logic        __out2;  // byte ready
  logic [15:0] __out3;  // words popped, wrapping

  modport master (
    output __in0, __in1, __in2, __in3,
    input  __out0, __out1, __out2, __out3
  );

  modport slave (
    input  __in0, __in1, __in2, __in3,
    output __out0, __out1, __out2, __out3
  );

endinterface

// File: rtl/word_fifo.sv
// Small word FIFO: power-of-two depth, wrapping pointers, occupancy counter.
module word_fifo
  import byte_pair_packer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  word_t din,
  output word_t dout,
  output logic  full,
  output logic  empty
);

  localparam int AW = clog2(DEPTH);

  word_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // NOTE: storage is reset too, because the head entry is visible on the
  // output straight after reset and must read as zero rather than X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/byte_pair_packer.sv
// Packs consecutive bytes into 16-bit words, with flush padding of an odd
// trailing byte and a wrapping count of words delivered downstream.
module byte_pair_packer
  import byte_pair_packer_pkg::*;
#(
  parameter int    DEPTH     = 2,
  parameter bit    FIRST_LOW = 1'b1,
  parameter byte_t PAD       = PAD_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  byte_pair_packer_if.slave bus
);

  pair_state_e state;
  byte_t       held;
  logic [15:0] pop_count;

  logic  full, empty;
  logic  push, pop, space, accept, flush_go;
  word_t push_word;
  word_t head;

  assign pop      = ~empty & bus.__in3;
  assign space    = ~full | bus.__in3;
  assign accept   = bus.__in1 & bus.__out2;
  assign flush_go = bus.__in2 & ~bus.__in1 & (state == HALF) & space;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    push      = 1'b0;
    push_word = '0;
    if (state == HALF && accept) begin
      push      = 1'b1;
      push_word = FIRST_LOW ? {bus.__in0, held} : {held, bus.__in0};
    end else if (flush_go) begin
      push      = 1'b1;
      push_word = FIRST_LOW ? {PAD, held} : {held, PAD};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      held      <= '0;
      pop_count <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          held  <= bus.__in0;
          state <= HALF;
        end
        HALF: if (accept || flush_go) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (pop) pop_count <= pop_count + 1'b1;
    end
  end

  word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_word),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Ready looks only at state and downstream ready, never at byte valid.
  assign bus.__out0 = head;
  assign bus.__out1 = ~empty;
  assign bus.__out2 = (state == IDLE) | space;
  assign bus.__out3 = pop_count;

endmodule

// File: tb/tb_byte_pair_packer.sv
// Directed bench for byte_pair_packer: both byte orders, backpressure, flush,
// counter wrap and asynchronous reset.
module tb_byte_pair_packer;
  import byte_pair_packer_pkg::*;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  byte_pair_packer_if bus_lo ();
  byte_pair_packer_if bus_hi ();

  byte_pair_packer #(.DEPTH(2), .FIRST_LOW(1'b1), .PAD(8'h00)) dut_lo (
    .clk (clk),
    .rst (rst),
    .bus (bus_lo)
  );

  byte_pair_packer #(.DEPTH(2), .FIRST_LOW(1'b0), .PAD(8'h00)) dut_hi (
    .clk (clk),
    .rst (rst),
    .bus (bus_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic cmp16(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset;
    if (bus_lo.__out0 !== 16'h0000) begin tests_failed++; $display("FAIL reset_out0: got %h expected 0000", bus_lo.__out0); end
    tests_run++;
    if (bus_lo.__out1 !== 1'b0) begin tests_failed++; $display("FAIL reset_out1: got %b expected 0", bus_lo.__out1); end
    tests_run++;
    if (bus_lo.__out2 !== 1'b1) begin tests_failed++; $display("FAIL reset_out2: got %b expected 1", bus_lo.__out2); end
    tests_run++;
    if (bus_lo.__out3 !== 16'h0000) begin tests_failed++; $display("FAIL reset_out3: got %h expected 0000", bus_lo.__out3); end
    tests_run++;
  endtask

  task automatic test_first_low;
    bus_lo.__in3 = 1'b1;
    bus_lo.__in0 = 8'h34; bus_lo.__in1 = 1'b1;
    @(negedge clk);
    bus_lo.__in0 = 8'h12;
    @(negedge clk);
    bus_lo.__in1 = 1'b0;
    cmp16("low_valid", 16'(bus_lo.__out1), 16'h0001);
    cmp16("low_word", bus_lo.__out0, 16'h1234);
    @(negedge clk);
    cmp16("low_valid_after_pop", 16'(bus_lo.__out1), 16'h0000);
    cmp16("low_count", bus_lo.__out3, 16'h0001);
    bus_lo.__in3 = 1'b0;
  endtask

  task automatic test_first_high;
    bus_hi.__in3 = 1'b1;
    bus_hi.__in0 = 8'h34; bus_hi.__in1 = 1'b1;
    @(negedge clk);
    bus_hi.__in0 = 8'h12;
    @(negedge clk);
    bus_hi.__in1 = 1'b0;
    cmp16("high_valid", 16'(bus_hi.__out1), 16'h0001);
    cmp16("high_word", bus_hi.__out0, 16'h3412);
    @(negedge clk);
    cmp16("high_count", bus_hi.__out3, 16'h0001);
    bus_hi.__in3 = 1'b0;
  endtask

  task automatic test_back_to_back;
    byte_t seq [5];
    seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bus_lo.__in3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_lo.__in0 = seq[i]; bus_lo.__in1 = 1'b1;
      @(negedge clk);
    end
    bus_lo.__in0 = 8'h66;
    #1;
    cmp16("bp_ready_stalled", 16'(bus_lo.__out2), 16'h0000);
    cmp16("bp_head", bus_lo.__out0, 16'h2211);
    @(negedge clk);
    @(negedge clk);
    cmp16("bp_still_stalled", 16'(bus_lo.__out2), 16'h0000);
    cmp16("bp_head_held", bus_lo.__out0, 16'h2211);
    bus_lo.__in3 = 1'b1;
    #1;
    cmp16("bp_ready_on_pop", 16'(bus_lo.__out2), 16'h0001);
    @(negedge clk);
    bus_lo.__in1 = 1'b0;
    cmp16("bp_word2", bus_lo.__out0, 16'h4433);
    cmp16("bp_count2", bus_lo.__out3, 16'h0002);
    @(negedge clk);
    cmp16("bp_word3", bus_lo.__out0, 16'h6655);
    cmp16("bp_count3", bus_lo.__out3, 16'h0003);
    @(negedge clk);
    cmp16("bp_drained", 16'(bus_lo.__out1), 16'h0000);
    cmp16("bp_count4", bus_lo.__out3, 16'h0004);
    bus_lo.__in3 = 1'b0;
  endtask

  task automatic test_flush;
    bus_lo.__in3 = 1'b0;
    bus_lo.__in0 = 8'hAB; bus_lo.__in1 = 1'b1;
    @(negedge clk);
    bus_lo.__in1 = 1'b0; bus_lo.__in2 = 1'b1;
    @(negedge clk);
    bus_lo.__in2 = 1'b0;
    cmp16("flush_valid", 16'(bus_lo.__out1), 16'h0001);
    cmp16("flush_word", bus_lo.__out0, 16'h00AB);
    bus_lo.__in2 = 1'b1;
    @(negedge clk);
    bus_lo.__in2 = 1'b0;
    @(negedge clk);
    bus_lo.__in3 = 1'b1;
    @(negedge clk);
    bus_lo.__in3 = 1'b0;
    cmp16("flush_empty_ignored", 16'(bus_lo.__out1), 16'h0000);
    cmp16("flush_count", bus_lo.__out3, 16'h0005);
    cmp16("flush_ready_idle", 16'(bus_lo.__out2), 16'h0001);
  endtask

  task automatic test_flush_full;
    byte_t seq [5];
    seq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB5};
    bus_lo.__in3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_lo.__in0 = seq[i]; bus_lo.__in1 = 1'b1;
      @(negedge clk);
    end
    bus_lo.__in1 = 1'b0; bus_lo.__in2 = 1'b1;
    #1;
    cmp16("ff_ready_blocked", 16'(bus_lo.__out2), 16'h0000);
    @(negedge clk);
    @(negedge clk);
    cmp16("ff_no_push_head", bus_lo.__out0, 16'hA2A1);
    cmp16("ff_no_pop_count", bus_lo.__out3, 16'h0005);
    bus_lo.__in3 = 1'b1;
    @(negedge clk);
    bus_lo.__in2 = 1'b0; bus_lo.__in3 = 1'b0;
    cmp16("ff_word2", bus_lo.__out0, 16'hA4A3);
    cmp16("ff_count6", bus_lo.__out3, 16'h0006);
    cmp16("ff_idle_after_flush", 16'(bus_lo.__out2), 16'h0001);
    bus_lo.__in3 = 1'b1;
    @(negedge clk);
    cmp16("ff_padded_word", bus_lo.__out0, 16'h00B5);
    cmp16("ff_count7", bus_lo.__out3, 16'h0007);
    @(negedge clk);
    cmp16("ff_drained", 16'(bus_lo.__out1), 16'h0000);
    cmp16("ff_count8", bus_lo.__out3, 16'h0008);
    bus_lo.__in3 = 1'b0;
  endtask

  task automatic test_count_wrap;
    logic [15:0] exp_cnt [3];
    exp_cnt = '{16'hFFFF, 16'h0000, 16'h0001};
    // Preload stands in for 65534 real pops, which would take too long.
    force dut_lo.pop_count = 16'hFFFE;
    #1;
    release dut_lo.pop_count;
    cmp16("wrap_preload", bus_lo.__out3, 16'hFFFE);
    bus_lo.__in3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_lo.__in0 = 8'(2 * i); bus_lo.__in1 = 1'b1;
      @(negedge clk);
      bus_lo.__in0 = 8'(2 * i + 1);
      @(negedge clk);
      bus_lo.__in1 = 1'b0;
      @(negedge clk);
      cmp16($sformatf("wrap_count%0d", i), bus_lo.__out3, exp_cnt[i]);
    end
    bus_lo.__in3 = 1'b0;
  endtask

  task automatic test_async_reset;
    byte_t seq [3];
    seq = '{8'h77, 8'h88, 8'h99};
    bus_lo.__in3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_lo.__in0 = seq[i]; bus_lo.__in1 = 1'b1;
      @(negedge clk);
    end
    bus_lo.__in1 = 1'b0;
    cmp16("ar_queued", 16'(bus_lo.__out1), 16'h0001);
    #2;
    rst = 1'b0;
    #1;
    cmp16("ar_valid", 16'(bus_lo.__out1), 16'h0000);
    cmp16("ar_count", bus_lo.__out3, 16'h0000);
    cmp16("ar_ready", 16'(bus_lo.__out2), 16'h0001);
    cmp16("ar_head", bus_lo.__out0, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    bus_lo.__in0 = 8'h01; bus_lo.__in1 = 1'b1;
    @(negedge clk);
    bus_lo.__in0 = 8'h02;
    @(negedge clk);
    bus_lo.__in1 = 1'b0;
    cmp16("ar_new_valid", 16'(bus_lo.__out1), 16'h0001);
    cmp16("ar_new_word", bus_lo.__out0, 16'h0201);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b0;
    bus_lo.__in0 = '0; bus_lo.__in1 = 1'b0; bus_lo.__in2 = 1'b0; bus_lo.__in3 = 1'b0;
    bus_hi.__in0 = '0; bus_hi.__in1 = 1'b0; bus_hi.__in2 = 1'b0; bus_hi.__in3 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    test_reset;
    test_first_low;
    test_first_high;
    test_back_to_back;
    test_flush;
    test_flush_full;
    test_count_wrap;
    test_async_reset;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
